// File: rtl/packet_injector.sv
// Packet injection stage: buffers whole packets from a producer and serializes
// them flit-by-flit onto a router channel under credit-based flow control.
module packet_injector #(
  parameter int FLIT_WIDTH   = 32,
  parameter int PACKET_FLITS = 5,
  parameter int QUEUE_DEPTH  = 2,
  parameter int BUFFER_DEPTH = 4,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [FLIT_WIDTH*PACKET_FLITS-1:0] packet_din,
  input  logic                               packet_valid_din,
  output logic                               packet_ready_dout,
  output logic [FLIT_WIDTH-1:0]              channel_dout,
  output logic                               flit_valid_dout,
  input  logic                               credit_in_din,
  output logic                               busy_dout,
  output logic [COUNT_WIDTH-1:0]             packets_sent_dout,
  output logic                               credit_overflow_dout
);

  localparam int PKT_W = FLIT_WIDTH * PACKET_FLITS;
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int IDX_W = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;
  localparam int CRD_W = $clog2(BUFFER_DEPTH + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_FLITS - 1);
  localparam logic [CRD_W-1:0] MAX_CRD  = CRD_W'(BUFFER_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Handshake: a packet transfers on a rising edge when packet_valid_din and
  // packet_ready_dout are both high; ready depends only on registered state.

  logic [PKT_W-1:0]       mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CRD_W-1:0]       credits_q, credits_d;
  state_e                 state_q, state_d;
  logic [FLIT_WIDTH-1:0]  channel_q, channel_d;
  logic                   flit_valid_q, flit_valid_d;
  logic [COUNT_WIDTH-1:0] sent_q, sent_d;
  logic                   overflow_q, overflow_d;

  logic                   push;
  logic                   launch;
  logic                   last_launch;
  logic [PKT_W-1:0]       head_pkt;
  logic [FLIT_WIDTH-1:0]  head_flit;

  assign packet_ready_dout    = (count_q < FULL_CNT);
  assign busy_dout            = (count_q != '0) || (state_q == SEND);
  assign channel_dout         = channel_q;
  assign flit_valid_dout      = flit_valid_q;
  assign packets_sent_dout    = sent_q;
  assign credit_overflow_dout = overflow_q;

  assign head_pkt  = mem_q[rd_ptr_q];
  assign head_flit = head_pkt[int'(idx_q)*FLIT_WIDTH +: FLIT_WIDTH];

  always_comb begin
    push         = packet_valid_din && packet_ready_dout;
    // The head launches straight from IDLE so the header leaves one cycle
    // after acceptance; only an empty queue or no credit blocks a launch.
    launch       = (count_q != '0) && (credits_q != '0);
    last_launch  = launch && (idx_q == LAST_IDX);

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    idx_d        = idx_q;
    credits_d    = credits_q;
    state_d      = state_q;
    channel_d    = channel_q;
    flit_valid_d = launch;
    sent_d       = sent_q;
    overflow_d   = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (last_launch) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      sent_d   = sent_q + COUNT_WIDTH'(1);
    end

    case ({push, last_launch})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (launch) begin
      channel_d = head_flit;
      idx_d     = last_launch ? '0 : idx_q + IDX_W'(1);
    end

    // A return that finds the counter already full is a protocol error:
    // the counter saturates and the sticky flag records it.
    case ({launch, credit_in_din})
      2'b10: credits_d = credits_q - CRD_W'(1);
      2'b01: begin
        if (credits_q == MAX_CRD) begin
          overflow_d = 1'b1;
        end else begin
          credits_d = credits_q + CRD_W'(1);
        end
      end
      default: credits_d = credits_q;
    endcase

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_launch && (count_d == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= packet_din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      credits_q    <= MAX_CRD;
      state_q      <= IDLE;
      channel_q    <= '0;
      flit_valid_q <= 1'b0;
      sent_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      credits_q    <= credits_d;
      state_q      <= state_d;
      channel_q    <= channel_d;
      flit_valid_q <= flit_valid_d;
      sent_q       <= sent_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_packet_injector.sv
// Bench for packet_injector: directed scenarios plus a randomized run against
// a packet-level reference (accepted packets expand into an expected flit queue).
module tb_packet_injector;

  localparam int FW = 32;
  localparam int PF = 5;
  localparam int QD = 2;
  localparam int BD = 4;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [FW*PF-1:0] packet_din;
  logic             packet_valid_din;
  logic             packet_ready_dout;
  logic [FW-1:0]    channel_dout;
  logic             flit_valid_dout;
  logic             credit_in_din;
  logic             busy_dout;
  logic [CW-1:0]    packets_sent_dout;
  logic             credit_overflow_dout;

  always #5 clk = ~clk;

  packet_injector #(
    .FLIT_WIDTH(FW), .PACKET_FLITS(PF), .QUEUE_DEPTH(QD),
    .BUFFER_DEPTH(BD), .COUNT_WIDTH(CW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .packet_din           (packet_din),
    .packet_valid_din     (packet_valid_din),
    .packet_ready_dout    (packet_ready_dout),
    .channel_dout         (channel_dout),
    .flit_valid_dout      (flit_valid_dout),
    .credit_in_din        (credit_in_din),
    .busy_dout            (busy_dout),
    .packets_sent_dout    (packets_sent_dout),
    .credit_overflow_dout (credit_overflow_dout)
  );

  logic [FW-1:0]    exp_q[$];
  logic [FW*PF-1:0] pend_q[$];
  int               tests_run;
  int               tests_failed;
  int               flits_rcvd;
  int               credits_ret;
  int               credit_mode;   // 0 manual, 1 echo each received flit, 2 random sink
  bit               fire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW*PF-1:0] make_pkt(input logic [FW-1:0] base);
    logic [FW*PF-1:0] p;
    p = '0;
    for (int i = 0; i < PF; i++) p[i*FW +: FW] = base + FW'(i);
    return p;
  endfunction

  // One clock: retire last cycle's accepted packet into the expected stream,
  // then drive producer and credit inputs for the new cycle.
  task automatic tick();
    logic [FW*PF-1:0] p;
    int occ;
    @(posedge clk);
    #1;
    if (fire) begin
      p = pend_q.pop_front();
      for (int i = 0; i < PF; i++) exp_q.push_back(p[i*FW +: FW]);
    end
    packet_valid_din = (pend_q.size() > 0) && ((credit_mode != 2) || ($urandom_range(0, 3) != 0));
    packet_din       = (pend_q.size() > 0) ? pend_q[0] : '0;
    credit_in_din    = 1'b0;
    if (credit_mode == 1) begin
      credit_in_din = flit_valid_dout;
    end else if (credit_mode == 2) begin
      occ = flits_rcvd - credits_ret;
      if (occ > 0 && $urandom_range(0, 3) != 0) begin
        credit_in_din = 1'b1;
        credits_ret++;
      end
    end
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick();
      @(negedge clk);
      if (flit_valid_dout) cnt++;
    end
  endtask

  // Asserts reset away from any clock edge, checks the reset state, releases.
  task automatic do_reset();
    @(posedge clk);
    #3;
    packet_valid_din = 1'b0;
    credit_in_din    = 1'b0;
    credit_mode      = 0;
    reset            = 1'b0;
    #1;
    check("rst_flit_valid", flit_valid_dout, 0);
    check("rst_ready", packet_ready_dout, 1);
    check("rst_busy", busy_dout, 0);
    check("rst_sent", packets_sent_dout, 0);
    check("rst_overflow", credit_overflow_dout, 0);
    check("rst_channel", channel_dout, 0);
    pend_q.delete();
    exp_q.delete();
    fire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int n_in, n_out, start, cyc, npk, occ;
    logic [FW*PF-1:0] rp;

    reset = 1'b0;
    packet_din = '0;
    packet_valid_din = 1'b0;
    credit_in_din = 1'b0;
    credit_mode = 0;
    tests_run = 0;
    tests_failed = 0;
    flits_rcvd = 0;
    credits_ret = 0;
    fire = 1'b0;

    // Monitor: records handshakes and checks every presented flit against the scoreboard.
    fork
      forever begin
        @(negedge clk);
        fire = reset && packet_valid_din && packet_ready_dout;
        if (reset && flit_valid_dout) begin
          flits_rcvd++;
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL stray_flit: got %0h expected no flit", channel_dout);
          end else begin
            check("flit_data", channel_dout, exp_q.pop_front());
          end
        end
        if (reset && credit_mode == 2) begin
          occ = flits_rcvd - credits_ret;
          tests_run++;
          if (occ > BD) begin
            tests_failed++;
            $display("FAIL sink_occupancy: got %0d expected at most %0d", occ, BD);
          end
        end
      end
    join_none

    do_reset();

    // Single packet, 4 credits, no returns; then one credit releases the tail.
    pend_q.push_back(make_pkt(32'hA0));
    n_in = 0; n_out = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      @(negedge clk);
      if (k == 2) check("t1_header_latency", {flit_valid_dout, channel_dout[30:0]}, {1'b1, 31'hA0});
      if (k >= 2 && k <= 5) n_in += int'(flit_valid_dout);
      else n_out += int'(flit_valid_dout);
    end
    check("t1_four_flits", n_in, 4);
    check("t1_stall_idle", n_out, 0);
    check("t1_busy_stalled", busy_dout, 1);
    tick(); credit_in_din = 1'b1; @(negedge clk);
    tick(); @(negedge clk);
    check("t1_tail_not_yet", flit_valid_dout, 0);
    tick(); @(negedge clk);
    check("t1_tail_valid", flit_valid_dout, 1);
    check("t1_tail_data", channel_dout, 32'hA4);
    tick(); @(negedge clk);
    check("t1_sent", packets_sent_dout, 1);
    check("t1_busy_done", busy_dout, 0);
    check("t1_drained", exp_q.size(), 0);

    // Two packets back-to-back with a credit echoed for every flit.
    do_reset();
    credit_mode = 1;
    pend_q.push_back(make_pkt(32'hB0));
    pend_q.push_back(make_pkt(32'hC0));
    n_in = 0; n_out = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      @(negedge clk);
      if (k >= 2 && k <= 11) n_in += int'(flit_valid_dout);
      else n_out += int'(flit_valid_dout);
    end
    check("t2_ten_consecutive", n_in, 10);
    check("t2_no_extra", n_out, 0);
    check("t2_sent", packets_sent_dout, 2);
    check("t2_no_overflow", credit_overflow_dout, 0);
    check("t2_drained", exp_q.size(), 0);

    // Four packets offered without credit returns: queue fills, then one credit.
    do_reset();
    for (int i = 0; i < 4; i++) pend_q.push_back(make_pkt(32'h100 + 32'(i * 16)));
    count_valid(10, n_in);
    check("t3_stall_flits", n_in, 4);
    check("t3_two_accepted", pend_q.size(), 2);
    check("t3_ready_low", packet_ready_dout, 0);
    tick(); credit_in_din = 1'b1; @(negedge clk);
    check("t3_ready_still_low", packet_ready_dout, 0);
    tick(); @(negedge clk);
    check("t3_tail_pending", flit_valid_dout, 0);
    tick(); @(negedge clk);
    check("t3_tail_valid", flit_valid_dout, 1);
    check("t3_ready_rises", packet_ready_dout, 1);
    tick(); @(negedge clk);
    check("t3_third_accepted", pend_q.size(), 1);
    check("t3_ready_full_again", packet_ready_dout, 0);
    check("t3_p2_stalled", flit_valid_dout, 0);

    // Credit returned while idle at full credit.
    do_reset();
    tick(); credit_in_din = 1'b1; @(negedge clk);
    tick(); @(negedge clk);
    check("t4_overflow_set", credit_overflow_dout, 1);
    count_valid(3, n_in);
    check("t4_overflow_sticky", credit_overflow_dout, 1);
    pend_q.push_back(make_pkt(32'hD0));
    count_valid(12, n_in);
    check("t4_credits_saturated", n_in, 4);
    check("t4_overflow_still", credit_overflow_dout, 1);

    // Reset in the middle of a packet with another queued.
    do_reset();
    pend_q.push_back(make_pkt(32'hE0));
    pend_q.push_back(make_pkt(32'hF0));
    start = flits_rcvd;
    cyc = 0;
    while ((flits_rcvd - start) < 2 && cyc < 20) begin
      tick();
      @(negedge clk);
      cyc++;
    end
    check("t5_two_flits_seen", flits_rcvd - start, 2);
    do_reset();
    count_valid(8, n_in);
    check("t5_no_stale_flits", n_in, 0);
    check("t5_busy", busy_dout, 0);
    check("t5_ready", packet_ready_dout, 1);
    check("t5_sent", packets_sent_dout, 0);
    pend_q.push_back(make_pkt(32'h200));
    count_valid(12, n_in);
    check("t5_credits_restored", n_in, 4);

    // One credit in hand, each launch paired with a return.
    do_reset();
    pend_q.push_back(make_pkt(32'h300));
    pend_q.push_back(make_pkt(32'h310));
    pend_q.push_back(make_pkt(32'h320));
    count_valid(10, n_in);
    check("t6_initial_stall", n_in, 4);
    n_in = 0; n_out = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k <= 10) credit_in_din = 1'b1;
      @(negedge clk);
      if (k >= 2 && k <= 12) n_in += int'(flit_valid_dout);
      else n_out += int'(flit_valid_dout);
    end
    check("t6_streamed", n_in, 11);
    check("t6_then_stall", n_out, 0);
    check("t6_sent", packets_sent_dout, 3);
    check("t6_drained", exp_q.size(), 0);

    // Randomized traffic against a sink that frees slots at random.
    do_reset();
    credits_ret = 0;
    flits_rcvd = 0;
    credit_mode = 2;
    npk = 40;
    for (int i = 0; i < npk; i++) begin
      for (int j = 0; j < PF; j++) rp[j*FW +: FW] = $urandom;
      pend_q.push_back(rp);
    end
    cyc = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < 4000) begin
      tick();
      @(negedge clk);
      cyc++;
    end
    check("rand_drained", pend_q.size() + exp_q.size(), 0);
    count_valid(4, n_in);
    check("rand_no_extra", n_in, 0);
    check("rand_sent", packets_sent_dout, npk);
    check("rand_no_overflow", credit_overflow_dout, 0);
    check("rand_busy", busy_dout, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/packet_injector.md
Name: packet_injector

Overview:
- Synthesizable injection stage that sits between the packet generator (packet-level producer) and a router input port.
- Accepts whole packets (one header flit plus four data flits) over a valid/ready handshake and buffers them in a small packet queue.
- Serializes each packet flit-by-flit onto the router channel, using credit-based flow control against the router's input buffer.
- Provides injection statistics and a sticky credit-protocol error flag for performance benches.

Parameters:
FLIT_WIDTH, 32, width of one flit / channel
PACKET_FLITS, 5, flits per packet (flit 0 = header)
QUEUE_DEPTH, 2, packets buffered inside the block (power of 2)
BUFFER_DEPTH, 4, downstream router input-buffer depth in flits = initial credits
COUNT_WIDTH, 16, width of packets_sent_dout

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
packet_din  in  FLIT_WIDTH*PACKET_FLITS  packet; flit i = packet_din[i*FLIT_WIDTH +: FLIT_WIDTH]
packet_valid_din  in  1  producer offers packet_din
packet_ready_dout  out  1  queue can accept a packet this cycle
channel_dout  out  FLIT_WIDTH  flit to router (registered)
flit_valid_dout  out  1  channel_dout valid this cycle (registered)
credit_in_din  in  1  one-cycle pulse = one flit slot freed downstream
busy_dout  out  1  queue non-empty or packet in flight
packets_sent_dout  out  COUNT_WIDTH  packets fully injected, wraps
credit_overflow_dout  out  1  sticky: credit returned while counter at BUFFER_DEPTH

Behaviour:
- Reset (reset=0, async): queue emptied, rd/wr pointers 0, flit index 0, credits=BUFFER_DEPTH, FSM=IDLE, channel_dout=0, flit_valid_dout=0, packets_sent_dout=0, credit_overflow_dout=0, busy_dout=0; packet_ready_dout=1. Any partially sent packet is discarded; no further flits of it are sent after release.
- Accept: packet written at the rising edge ending a cycle with packet_valid_din & packet_ready_dout. packet_ready_dout = (count < QUEUE_DEPTH), derived from registers only, no combinational path from packet_valid_din. When full, nothing is accepted even if the head frees that same cycle.
- Queue entry is freed at the edge on which its last flit (index PACKET_FLITS-1) is launched.
- FSM states:
  - IDLE: waiting for a packet.
  - SEND: serializing the head entry.
  - IDLE->SEND when count>0.
  - In SEND, flit[idx] of the head entry is launched in any cycle where credits>0: channel_dout/flit_valid_dout registered at the next edge, credits decremented, idx incremented.
  - credits==0 → no launch; flit_valid_dout=0 next cycle; channel_dout holds its last value.
  - After launching the last flit: idx=0, packets_sent_dout increments (wraps at 2^COUNT_WIDTH), and the head pops. If another packet is queued, the FSM stays in SEND and the next header launches in the following cycle (no bubble); otherwise it returns to IDLE.
- Latency: a packet accepted in cycle t (queue previously empty, credits>0) has its header visible with flit_valid_dout=1 in cycle t+2. With credits available, flits occupy consecutive cycles.
- Credits:
  - Counter width $clog2(BUFFER_DEPTH+1).
  - credit_in_din in cycle t updates the counter at the end of t and is usable in t+1.
  - Launch and return in the same cycle leave the counter unchanged.
  - A return at BUFFER_DEPTH with no launch: counter saturates and credit_overflow_dout sets, cleared only by reset.
- busy_dout = (count>0) | (state==SEND).
- flit_valid_dout is never high for more than PACKET_FLITS consecutive flits of one packet. Flit order within a packet is always 0..PACKET_FLITS-1.

Test Plan:
- Single packet (flits 0xA0..0xA4), credits=4, no returns: 0xA0..0xA3 in cycles t+2..t+5, then valid low. Pulse credit_in_din once → 0xA4 two cycles later; packets_sent_dout=1, busy_dout=0 afterwards.
- Two packets back-to-back with credit_in_din pulsed the cycle after every launch: 10 consecutive valid cycles with no bubble at the packet boundary; packets_sent_dout=2.
- No credit returns, offer 4 packets: first packet stalls after 4 flits; 2 packets accepted (ready low thereafter); the producer holds packets 3/4. One credit pulse → flit 4 sent, ready rises the next cycle, packet 3 accepted.
- Pulse credit_in_din while idle with credits=4: credit_overflow_dout=1 and stays set; credits remain 4 (next packet launches exactly 4 flits before stalling).
- Assert reset after 2 flits of a packet with 1 more queued: flit_valid_dout=0 immediately; after release busy_dout=0, ready=1, packets_sent_dout=0, credits=4, and no stale flits appear.
- Credits=1 with a credit return coinciding with each launch: streaming continues without stall for 10 flits; counter ends at 1.
